// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared types for the pipeline stall/flush controller.
// Holds the SRAM wait FSM states and the output-priority case codes used for debug.
package pipe_ctrl_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } mem_state_t;

    localparam logic [1:0] PRIO_NONE   = 2'd0;
    localparam logic [1:0] PRIO_MEM    = 2'd1;
    localparam logic [1:0] PRIO_BRANCH = 2'd2;
    localparam logic [1:0] PRIO_HAZARD = 2'd3;

endpackage

// File: rtl/pipeline_hazard_ctrl_mem_wait_fsm.sv
// SRAM access wait tracker with a timeout watchdog.
// Produces the memory stall request and a sticky error flag once the watchdog fires.
module mem_wait_fsm
    import pipe_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic mem_req,
    input  logic sram_ready,
    output logic mem_stall,
    output logic mem_busy,
    output logic timeout_now,
    output logic mem_error
);

    localparam int unsigned CW = $clog2(MEM_TIMEOUT + 1);

    mem_state_t     state, state_next;
    logic [CW-1:0]  wait_cnt, wait_cnt_next;

    always_comb begin
        state_next    = state;
        wait_cnt_next = wait_cnt;
        timeout_now   = 1'b0;
        case (state)
            IDLE: begin
                if (mem_req && !sram_ready) begin
                    state_next    = WAIT;
                    wait_cnt_next = CW'(1);
                end
            end
            WAIT: begin
                if (sram_ready || !mem_req) begin
                    state_next    = IDLE;
                    wait_cnt_next = '0;
                end else if (wait_cnt == CW'(MEM_TIMEOUT)) begin
                    // stall is released in the timeout cycle itself
                    timeout_now   = 1'b1;
                    state_next    = IDLE;
                    wait_cnt_next = '0;
                end else begin
                    wait_cnt_next = wait_cnt + CW'(1);
                end
            end
            default: begin
                state_next    = IDLE;
                wait_cnt_next = '0;
            end
        endcase
    end

    assign mem_stall = mem_req && !sram_ready && !timeout_now;
    assign mem_busy  = (state == WAIT);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            wait_cnt  <= '0;
            mem_error <= 1'b0;
        end else begin
            state    <= state_next;
            wait_cnt <= wait_cnt_next;
            if (timeout_now) begin
                mem_error <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Central stall/flush controller for the 5-stage pipeline: RAW hazards,
// SRAM wait stretching and branch squash, plus saturating perf counters.
module pipeline_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int FWD_EN      = 1,
    parameter int MEM_TIMEOUT = 255,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       id_src1,
    input  logic             id_src1_valid,
    input  logic [3:0]       id_src2,
    input  logic             id_two_src,
    input  logic [3:0]       exe_dest,
    input  logic             exe_wb_en,
    input  logic             exe_mem_read,
    input  logic [3:0]       mem_dest,
    input  logic             mem_wb_en,
    input  logic             exe_branch_taken,
    input  logic             mem_req,
    input  logic             sram_ready,
    output logic             pc_freeze,
    output logic             ifid_freeze,
    output logic             idex_freeze,
    output logic             exmem_freeze,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic             memwb_flush,
    output logic             mem_busy,
    output logic             mem_error,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_count
);

    logic       mem_stall, timeout_now;
    logic       hit_exe, hit_mem, data_hazard;
    logic [1:0] prio_case;

    mem_wait_fsm #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_mem_wait (
        .clk        (clk),
        .rst        (rst),
        .mem_req    (mem_req),
        .sram_ready (sram_ready),
        .mem_stall  (mem_stall),
        .mem_busy   (mem_busy),
        .timeout_now(timeout_now),
        .mem_error  (mem_error)
    );

    assign hit_exe = (id_src1_valid && id_src1 == exe_dest) || (id_two_src && id_src2 == exe_dest);
    assign hit_mem = (id_src1_valid && id_src1 == mem_dest) || (id_two_src && id_src2 == mem_dest);

    assign data_hazard = (FWD_EN != 0)
        ? (exe_wb_en && exe_mem_read && hit_exe)
        : ((exe_wb_en && hit_exe) || (mem_wb_en && hit_mem));

    always_comb begin
        if (rst)                             prio_case = PRIO_NONE;
        else if (mem_stall && !timeout_now)  prio_case = PRIO_MEM;
        else if (exe_branch_taken)           prio_case = PRIO_BRANCH;
        else if (data_hazard)                prio_case = PRIO_HAZARD;
        else                                 prio_case = PRIO_NONE;
    end

    always_comb begin
        pc_freeze    = 1'b0;
        ifid_freeze  = 1'b0;
        idex_freeze  = 1'b0;
        exmem_freeze = 1'b0;
        ifid_flush   = 1'b0;
        idex_flush   = 1'b0;
        memwb_flush  = 1'b0;
        case (prio_case)
            PRIO_MEM: begin
                pc_freeze    = 1'b1;
                ifid_freeze  = 1'b1;
                idex_freeze  = 1'b1;
                exmem_freeze = 1'b1;
                memwb_flush  = 1'b1;
            end
            PRIO_BRANCH: begin
                ifid_flush = 1'b1;
                idex_flush = 1'b1;
            end
            PRIO_HAZARD: begin
                pc_freeze   = 1'b1;
                ifid_freeze = 1'b1;
                idex_flush  = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cycles <= '0;
            flush_count  <= '0;
        end else begin
            if (pc_freeze && stall_cycles != '1) begin
                stall_cycles <= stall_cycles + CNT_W'(1);
            end
            if (prio_case == PRIO_BRANCH && flush_count != '1) begin
                flush_count <= flush_count + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Randomized bench for pipeline_hazard_ctrl with a cycle-level reference model.
// Two instances: forwarding + short watchdog, and no forwarding + 8-bit counters.
module tb_pipeline_hazard_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [3:0] id_src1 = '0, id_src2 = '0, exe_dest = '0, mem_dest = '0;
    logic id_src1_valid = 1'b0, id_two_src = 1'b0;
    logic exe_wb_en = 1'b0, exe_mem_read = 1'b0, mem_wb_en = 1'b0;
    logic exe_branch_taken = 1'b0, mem_req = 1'b0, sram_ready = 1'b0;

    logic a_pcf, a_ifidf, a_idexf, a_exmemf, a_ifidfl, a_idexfl, a_memwbfl, a_busy, a_err;
    logic b_pcf, b_ifidf, b_idexf, b_exmemf, b_ifidfl, b_idexfl, b_memwbfl, b_busy, b_err;
    logic [31:0] a_stall, a_flush;
    logic [7:0]  b_stall, b_flush;

    localparam int unsigned TMO_A = 4;
    localparam int unsigned TMO_B = 6;

    always #5 clk = ~clk;

    pipeline_hazard_ctrl #(.FWD_EN(1), .MEM_TIMEOUT(TMO_A), .CNT_W(32)) dut_a (
        .clk(clk), .rst(rst), .id_src1(id_src1), .id_src1_valid(id_src1_valid),
        .id_src2(id_src2), .id_two_src(id_two_src), .exe_dest(exe_dest),
        .exe_wb_en(exe_wb_en), .exe_mem_read(exe_mem_read), .mem_dest(mem_dest),
        .mem_wb_en(mem_wb_en), .exe_branch_taken(exe_branch_taken), .mem_req(mem_req),
        .sram_ready(sram_ready), .pc_freeze(a_pcf), .ifid_freeze(a_ifidf),
        .idex_freeze(a_idexf), .exmem_freeze(a_exmemf), .ifid_flush(a_ifidfl),
        .idex_flush(a_idexfl), .memwb_flush(a_memwbfl), .mem_busy(a_busy),
        .mem_error(a_err), .stall_cycles(a_stall), .flush_count(a_flush)
    );

    pipeline_hazard_ctrl #(.FWD_EN(0), .MEM_TIMEOUT(TMO_B), .CNT_W(8)) dut_b (
        .clk(clk), .rst(rst), .id_src1(id_src1), .id_src1_valid(id_src1_valid),
        .id_src2(id_src2), .id_two_src(id_two_src), .exe_dest(exe_dest),
        .exe_wb_en(exe_wb_en), .exe_mem_read(exe_mem_read), .mem_dest(mem_dest),
        .mem_wb_en(mem_wb_en), .exe_branch_taken(exe_branch_taken), .mem_req(mem_req),
        .sram_ready(sram_ready), .pc_freeze(b_pcf), .ifid_freeze(b_ifidf),
        .idex_freeze(b_idexf), .exmem_freeze(b_exmemf), .ifid_flush(b_ifidfl),
        .idex_flush(b_idexfl), .memwb_flush(b_memwbfl), .mem_busy(b_busy),
        .mem_error(b_err), .stall_cycles(b_stall), .flush_count(b_flush)
    );

    int n_chk = 0;
    int n_bad = 0;

    // Model state: cycles the current access has already waited, sticky error, counters
    int unsigned     wa, wb;
    bit              ea, eb;
    longint unsigned sa, fa, sb, fb;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit reads(input logic [3:0] d);
        return (id_src1_valid && id_src1 == d) || (id_two_src && id_src2 == d);
    endfunction

    // Expected {pc_f, ifid_f, idex_f, exmem_f, ifid_fl, idex_fl, memwb_fl, busy, err}
    function automatic logic [8:0] ref_vec(input bit fwd, input int unsigned tmo,
                                           input int unsigned waited, input bit err);
        logic [8:0] v;
        bit to, ms, hz;
        v  = '0;
        if (rst) return v;
        to = mem_req && !sram_ready && waited == tmo;
        ms = mem_req && !sram_ready && !to;
        hz = fwd ? (exe_wb_en && exe_mem_read && reads(exe_dest))
                 : ((exe_wb_en && reads(exe_dest)) || (mem_wb_en && reads(mem_dest)));
        if (ms) begin
            v[8:5] = 4'hF;
            v[2]   = 1'b1;
        end else if (exe_branch_taken) begin
            v[4] = 1'b1;
            v[3] = 1'b1;
        end else if (hz) begin
            v[8] = 1'b1;
            v[7] = 1'b1;
            v[3] = 1'b1;
        end
        v[1] = (waited > 0);
        v[0] = err;
        return v;
    endfunction

    task automatic model_reset();
        wa = 0; wb = 0; ea = 0; eb = 0;
        sa = 0; fa = 0; sb = 0; fb = 0;
    endtask

    task automatic advance(input int unsigned tmo, input logic [8:0] v, input longint unsigned maxc,
                           inout int unsigned waited, inout bit err,
                           inout longint unsigned sc, inout longint unsigned fc);
        bit to;
        to = mem_req && !sram_ready && waited == tmo;
        waited = (mem_req && !sram_ready && !to) ? waited + 1 : 0;
        if (to) err = 1'b1;
        if (v[8] && sc != maxc) sc++;
        if (v[4] && fc != maxc) fc++;
    endtask

    // Called at a negedge with inputs already driven; returns at the next negedge.
    task automatic cycle(input string tag);
        logic [8:0] va, vb;
        #2;
        va = ref_vec(1'b1, TMO_A, wa, ea);
        vb = ref_vec(1'b0, TMO_B, wb, eb);
        check({tag, ":a_out"}, {a_pcf, a_ifidf, a_idexf, a_exmemf, a_ifidfl, a_idexfl, a_memwbfl, a_busy, a_err}, va);
        check({tag, ":b_out"}, {b_pcf, b_ifidf, b_idexf, b_exmemf, b_ifidfl, b_idexfl, b_memwbfl, b_busy, b_err}, vb);
        check({tag, ":a_stall"}, a_stall, sa);
        check({tag, ":a_flush"}, a_flush, fa);
        check({tag, ":b_stall"}, b_stall, sb);
        check({tag, ":b_flush"}, b_flush, fb);
        @(posedge clk);
        if (rst) model_reset();
        else begin
            advance(TMO_A, va, 64'hFFFF_FFFF, wa, ea, sa, fa);
            advance(TMO_B, vb, 64'hFF, wb, eb, sb, fb);
        end
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        id_src1 = '0; id_src2 = '0; exe_dest = '0; mem_dest = '0;
        id_src1_valid = 0; id_two_src = 0; exe_wb_en = 0; exe_mem_read = 0;
        mem_wb_en = 0; exe_branch_taken = 0; mem_req = 0; sram_ready = 0;
    endtask

    int unsigned p_ready;

    initial begin
        model_reset();
        idle_inputs();
        @(negedge clk);
        cycle("reset");
        check("reset:a_busy", a_busy, 1'b0);
        check("reset:a_err", a_err, 1'b0);
        rst = 1'b0;

        // load-use on a forwarding core
        exe_mem_read = 1; exe_wb_en = 1; exe_dest = 4'd3; id_src1 = 4'd3; id_src1_valid = 1;
        cycle("loaduse");
        idle_inputs();
        cycle("loaduse_after");
        check("loaduse:a_stall1", a_stall, 32'd1);

        // ALU result: forwarded on a, stalls b; MEM-stage match on Rm stalls b
        exe_wb_en = 1; exe_dest = 4'd7; id_src1 = 4'd7; id_src1_valid = 1;
        cycle("alu_raw_exe");
        idle_inputs();
        mem_wb_en = 1; mem_dest = 4'd5; id_src2 = 4'd5; id_two_src = 1;
        cycle("alu_raw_mem");
        idle_inputs();

        // SRAM answers on the 4th cycle
        mem_req = 1;
        repeat (3) cycle("sram_wait");
        sram_ready = 1;
        cycle("sram_done");
        idle_inputs();
        cycle("sram_after");
        check("sram:a_busy_idle", a_busy, 1'b0);

        // taken branch held behind a memory stall
        mem_req = 1; exe_branch_taken = 1;
        repeat (2) cycle("br_stall");
        sram_ready = 1;
        cycle("br_release");
        idle_inputs();
        check("br:a_flush1", a_flush, 32'd1);
        cycle("br_after");

        // watchdog: SRAM never answers
        mem_req = 1;
        repeat (5) cycle("wdog");
        check("wdog:a_err_set", a_err, 1'b1);
        cycle("wdog_rerequest");
        idle_inputs();
        repeat (3) cycle("wdog_sticky");

        // randomized traffic in segments of varying SRAM responsiveness
        for (int seg = 0; seg < 30; seg++) begin
            case ($urandom_range(2, 0))
                0: p_ready = 10;
                1: p_ready = 50;
                default: p_ready = 90;
            endcase
            for (int c = 0; c < 50; c++) begin
                id_src1 = 4'($urandom_range(3, 0));
                id_src2 = 4'($urandom_range(3, 0));
                exe_dest = 4'($urandom_range(3, 0));
                mem_dest = 4'($urandom_range(3, 0));
                id_src1_valid = 1'($urandom_range(1, 0));
                id_two_src = 1'($urandom_range(1, 0));
                exe_wb_en = 1'($urandom_range(1, 0));
                exe_mem_read = 1'($urandom_range(1, 0));
                mem_wb_en = 1'($urandom_range(1, 0));
                exe_branch_taken = ($urandom_range(99, 0) < 15);
                mem_req = ($urandom_range(99, 0) < 60);
                sram_ready = ($urandom_range(99, 0) < p_ready);
                cycle("rand");
            end
        end

        // drive both 8-bit counters into saturation
        idle_inputs();
        exe_branch_taken = 1;
        repeat (270) cycle("sat_flush");
        idle_inputs();
        mem_req = 1;
        repeat (330) cycle("sat_stall");
        check("sat:b_flush_max", b_flush, 8'hFF);
        check("sat:b_stall_max", b_stall, 8'hFF);

        // asynchronous reset while an access is waiting
        idle_inputs();
        cycle("rst_pre");
        mem_req = 1;
        repeat (2) cycle("rst_wait");
        #1 rst = 1'b1;
        #1;
        check("rstw:a_out", {a_pcf, a_ifidf, a_idexf, a_exmemf, a_ifidfl, a_idexfl, a_memwbfl, a_busy, a_err}, 9'd0);
        check("rstw:b_out", {b_pcf, b_ifidf, b_idexf, b_exmemf, b_ifidfl, b_idexfl, b_memwbfl, b_busy, b_err}, 9'd0);
        check("rstw:a_cnt", {a_stall, a_flush}, 64'd0);
        check("rstw:b_cnt", {b_stall, b_flush}, 16'd0);
        model_reset();
        @(negedge clk);
        cycle("rst_hold");
        rst = 1'b0;
        repeat (3) cycle("rst_resume");

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
